md_issue_ctrl: RTL

- Sequencer and hazard controller for the multi-cycle multiply/divide unit and its HI/LO registers in the 5-stage MIPS pipeline.
- Decodes the E-stage instruction and issues a one-cycle start with an op code to the md datapath.
- Counts the op-dependent latency, generates the HI/LO result write, and handles mthi/mtlo writes.
- Stalls any D-stage instruction that touches HI/LO while the unit is busy.

---
 rtl/md_pkg.sv | 46 ++++
 rtl/md_issue_ctrl_if.sv | 30 +++
 rtl/md_decode.sv | 51 +++++
 rtl/md_issue_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : decode constants, md op encodings, FSM states, latency helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package md_pkg;

   localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
   localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MSUB  = 6'b000100;

   localparam logic [2:0] MD_MULTU = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_DIVU  = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_MSUB  = 3'd4;
   localparam logic [2:0] MD_NONE  = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

   function automatic int unsigned md_latency(input logic [2:0]  op,
                                              input int unsigned mult_lat,
                                              input int unsigned div_lat);
      return md_is_div(op) ? div_lat : mult_lat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_issue_ctrl_if.sv
// ============================================================================
// md_issue_ctrl_if : pipeline-side bundle of the md issue/hazard controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface md_issue_ctrl_if;
   logic [31:0] ir_e;
   logic [31:0] ir_d;
   logic        div_zero_e;
   logic        md_start;
   logic [2:0]  md_op;
   logic        res_we;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        stall_d;

   modport master (
      output ir_e, ir_d, div_zero_e,
      input  md_start, md_op, res_we, hi_we, lo_we, busy, stall_d
   );

   modport slave (
      input  ir_e, ir_d, div_zero_e,
      output md_start, md_op, res_we, hi_we, lo_we, busy, stall_d
   );
endinterface

`default_nettype wire

// File: rtl/md_decode.sv
// ============================================================================
// md_decode : classifies an instruction word for the md unit and HI/LO access
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module md_decode
   import md_pkg::*;
(
   input  wire logic [31:0] ir_i,
   output logic      [2:0]  md_op_o,
   output logic             is_hilo_use_o,
   output logic             is_mthi_o,
   output logic             is_mtlo_o
);

   logic [5:0] w_opc;
   logic [5:0] w_fn;
   logic       w_rd_hilo;
   logic       w_unused_fields;

   assign w_opc           = ir_i[31:26];
   assign w_fn            = ir_i[5:0];
   assign w_unused_fields = ^ir_i[25:6];

   always_comb begin
      md_op_o   = MD_NONE;
      w_rd_hilo = 1'b0;
      is_mthi_o = 1'b0;
      is_mtlo_o = 1'b0;
      if (w_opc == OPC_SPECIAL) begin
         case (w_fn)
            FN_MULTU:         md_op_o   = MD_MULTU;
            FN_MULT:          md_op_o   = MD_MULT;
            FN_DIVU:          md_op_o   = MD_DIVU;
            FN_DIV:           md_op_o   = MD_DIV;
            FN_MFHI, FN_MFLO: w_rd_hilo = 1'b1;
            FN_MTHI:          is_mthi_o = 1'b1;
            FN_MTLO:          is_mtlo_o = 1'b1;
            default:          ;
         endcase
      end else if ((w_opc == OPC_SPECIAL2) && (w_fn == FN_MSUB)) begin
         md_op_o = MD_MSUB;
      end
   end

   assign is_hilo_use_o = (md_op_o != MD_NONE) | w_rd_hilo | is_mthi_o | is_mtlo_o;

endmodule

`default_nettype wire

// File: rtl/md_issue_ctrl.sv
// ============================================================================
// md_issue_ctrl : issues md ops, times their latency, drives HI/LO writes
//                 and stalls D-stage HI/LO users while the unit is busy
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module md_issue_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   md_issue_ctrl_if.slave   md
);
   import md_pkg::*;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             dz_q, dz_d;

   logic [2:0]       w_e_op;
   logic             w_e_mthi, w_e_mtlo, w_e_use;
   logic [2:0]       w_d_op;
   logic             w_d_mthi, w_d_mtlo, w_d_use;
   logic             w_unused_dec;

   logic             w_start, w_res_we, w_hi_we, w_lo_we, w_busy;
   logic [2:0]       w_md_op;

   md_decode u_dec_e (
      .ir_i          (md.ir_e),
      .md_op_o       (w_e_op),
      .is_hilo_use_o (w_e_use),
      .is_mthi_o     (w_e_mthi),
      .is_mtlo_o     (w_e_mtlo)
   );

   md_decode u_dec_d (
      .ir_i          (md.ir_d),
      .md_op_o       (w_d_op),
      .is_hilo_use_o (w_d_use),
      .is_mthi_o     (w_d_mthi),
      .is_mtlo_o     (w_d_mtlo)
   );

   assign w_unused_dec = ^{w_e_use, w_d_op, w_d_mthi, w_d_mtlo};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         dz_q    <= dz_d;
      end
   end

   // Outputs are forced quiet while rst is low so a held reset never issues.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      dz_d     = dz_q;
      w_start  = 1'b0;
      w_md_op  = MD_NONE;
      w_res_we = 1'b0;
      w_hi_we  = 1'b0;
      w_lo_we  = 1'b0;
      if (rst) begin
         case (state_q)
            ST_IDLE: begin
               w_md_op = w_e_op;
               w_hi_we = w_e_mthi;
               w_lo_we = w_e_mtlo;
               if (w_e_op != MD_NONE) begin
                  w_start = 1'b1;
                  state_d = ST_RUN;
                  op_d    = w_e_op;
                  cnt_d   = CNT_W'(md_latency(w_e_op, MULT_LAT, DIV_LAT));
                  dz_d    = md_is_div(w_e_op) & md.div_zero_e;
               end
            end
            ST_RUN: begin
               w_md_op = op_q;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  w_res_we = !dz_q;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign w_busy = w_start | (rst & (state_q == ST_RUN));

   assign md.md_start = w_start;
   assign md.md_op    = w_md_op;
   assign md.res_we   = w_res_we;
   assign md.hi_we    = w_hi_we;
   assign md.lo_we    = w_lo_we;
   assign md.busy     = w_busy;
   assign md.stall_d  = w_busy & w_d_use;

endmodule

`default_nettype wire
